// File: rtl/pipe_stage_skid.sv
// Purpose: stage register carrying a control and a datapath bundle across a valid/ready boundary through a 2-entry skid buffer.
// Latency: one cycle from input handshake to output; full throughput while out_ready stays high.
// Backpressure: in_ready is decoded from registered state only (low when both entries are full); flush drops everything held.
module pipe_stage_skid #(
   parameter int                CTRL_W   = 16,
   parameter int                DATA_W   = 64,
   parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
   logic [DATA_W-1:0] main_data_q, skid_data_q;
   logic              load_main_in, load_main_skid, load_skid;
   logic              fire_in, fire_out;

   // Handshake strobes; ready and valid come from the state register only.
   assign in_ready  = (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign fire_in   = in_valid & in_ready;
   assign fire_out  = out_valid & out_ready;
   assign out_ctrl  = out_valid ? main_ctrl_q : NOP_CTRL;
   assign out_data  = main_data_q;

   // State register; reset takes priority over everything.
   always_ff @(posedge clk) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   // Next-state and entry-load decode; a flush discards the input beat too.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (fire_in) begin
                  load_main_in = 1'b1;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (fire_in && fire_out) begin
                  load_main_in = 1'b1;
               end else if (fire_in) begin
                  load_skid = 1'b1;
                  state_d   = TWO;
               end else if (fire_out) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_ready) begin
                  load_main_skid = 1'b1;
                  state_d        = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Entry storage; contents survive a flush, only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         if (load_main_in) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
         end else if (load_main_skid) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
         end
         if (load_skid) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
         end
      end
   end

   // Saturating count of cycles where downstream was ready but got nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (!out_valid && out_ready && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic against a queue model.
// Two instances share stimulus; the second uses a 4-bit bubble counter to exercise saturation.
// Every cycle all outputs are compared against the model shortly after the rising edge.
module tb_pipe_stage_skid;

   localparam int CW = 16;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;

   logic          in_ready, out_valid;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [15:0]   bubble_cnt;

   logic          in_ready_s, out_valid_s;
   logic [CW-1:0] out_ctrl_s;
   logic [DW-1:0] out_data_s;
   logic [3:0]    bubble_cnt_s;

   always #5 clk = ~clk;

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .NOP_CTRL(16'h0000), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .bubble_cnt(bubble_cnt)
   );

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .NOP_CTRL(16'h0000), .CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s), .out_data(out_data_s),
      .bubble_cnt(bubble_cnt_s)
   );

   // Reference model: a FIFO of capacity two plus the last value seen at its head.
   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } beat_t;

   beat_t       q[$];
   logic [DW-1:0] hold_data;
   int unsigned bub, bub4;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one clock edge of the abstract behaviour using the inputs present at that edge.
   task automatic model_step();
      beat_t b;
      int    sz;
      if (rst) begin
         q.delete();
         hold_data = '0;
         bub  = 0;
         bub4 = 0;
      end else begin
         sz = q.size();
         if (sz == 0 && out_ready) begin
            if (bub < 65535) bub++;
            if (bub4 < 15) bub4++;
         end
         if (flush) begin
            q.delete();
         end else begin
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (in_valid && sz < 2) begin
               b.c = in_ctrl;
               b.d = in_data;
               q.push_back(b);
            end
            if (q.size() > 0) hold_data = q[0].d;
         end
      end
   endtask

   task automatic check_outputs();
      logic          exp_v;
      logic [CW-1:0] exp_c;
      exp_v = (q.size() > 0);
      exp_c = exp_v ? q[0].c : 16'h0000;
      check("out_valid", out_valid, exp_v);
      check("out_ctrl", out_ctrl, exp_c);
      check("out_data", out_data, hold_data);
      check("in_ready", in_ready, q.size() < 2);
      check("bubble_cnt", bubble_cnt, bub);
      check("bubble_cnt_w4", bubble_cnt_s, bub4);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic r, input logic f, input logic iv,
                        input logic [CW-1:0] ic, input logic [DW-1:0] id, input logic ordy);
      rst       = r;
      flush     = f;
      in_valid  = iv;
      in_ctrl   = ic;
      in_data   = id;
      out_ready = ordy;
   endtask

   initial begin
      logic in_ready_before;
      hold_data = '0;
      bub  = 0;
      bub4 = 0;
      drive(1'b1, 1'b0, 1'b0, 16'h0, 64'h0, 1'b0);
      tick();
      tick();
      // Reset values
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_data", out_data, 64'h0);

      // Back-to-back stream with downstream always ready
      for (int i = 1; i <= 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 16'h0010 + 16'(i), 64'(i), 1'b1);
         tick();
         check("stream_data", out_data, 64'(i));
         check("stream_in_ready", in_ready, 1'b1);
      end
      check("stream_bubbles", bubble_cnt, 64'd1);
      drive(1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 1'b1);
      tick();

      // Stall: fill both entries, then drain in order
      drive(1'b0, 1'b0, 1'b1, 16'h00A1, 64'hA1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h00A2, 64'hA2, 1'b0);
      tick();
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_head", out_data, 64'hA1);
      drive(1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 1'b1);
      tick();
      check("drain_second", out_data, 64'hA2);
      check("drain_second_v", out_valid, 1'b1);
      tick();
      check("drain_empty", out_valid, 1'b0);

      // Flush while full, with a beat offered in the same cycle
      drive(1'b0, 1'b0, 1'b1, 16'h00B1, 64'hB1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h00B2, 64'hB2, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 16'h1234, 64'hFF, 1'b1);
      tick();
      check("flush_valid", out_valid, 1'b0);
      check("flush_ctrl", out_ctrl, 16'h0000);
      drive(1'b0, 1'b0, 1'b0, 16'h1234, 64'hFF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("flush_dropped", out_valid, 1'b0);
      end

      // Reset while full, then a normal beat
      drive(1'b0, 1'b0, 1'b1, 16'h00C1, 64'hC1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h00C2, 64'hC2, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 16'h00C3, 64'hC3, 1'b0);
      tick();
      check("rst_mid_valid", out_valid, 1'b0);
      check("rst_mid_data", out_data, 64'h0);
      check("rst_mid_ready", in_ready, 1'b1);
      check("rst_mid_bubble", bubble_cnt, 64'h0);
      drive(1'b0, 1'b0, 1'b1, 16'h0055, 64'h55, 1'b1);
      tick();
      check("after_rst_beat", out_data, 64'h55);
      check("after_rst_valid", out_valid, 1'b1);

      // Bubble counter saturation on the 4-bit instance
      drive(1'b1, 1'b0, 1'b0, 16'h0, 64'h0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 1'b1);
      for (int i = 0; i < 20; i++) tick();
      check("sat_w4", bubble_cnt_s, 64'd15);
      check("count_w16", bubble_cnt, 64'd20);

      // Randomized traffic
      for (int i = 0; i < 10000; i++) begin
         drive(($urandom_range(0, 999) == 0), ($urandom_range(0, 49) == 0),
               ($urandom_range(0, 3) != 0), 16'($urandom), {$urandom, $urandom},
               ($urandom_range(0, 2) != 0));
         // Wiggle out_ready mid-cycle: in_ready must not follow it
         if ((i % 7) == 0) begin
            in_ready_before = in_ready;
            out_ready = ~out_ready;
            #1;
            check("in_ready_comb", in_ready, q.size() < 2);
            check("in_ready_steady", in_ready, in_ready_before);
            out_ready = ~out_ready;
            #1;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field stage registers between pipeline stages (Id/Ex class).
- Carries one control bundle and one datapath bundle across a stage boundary with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput, stall back-pressure without a combinational ready path, flush-to-bubble, and a saturating bubble counter.
- Instantiated between any two stages; control fields are packed into in_ctrl and datapath fields (PC+1, Imm, R[ra], R[rb], SP, input port, instruction) into in_data.

Parameters:
- CTRL_W, 16: width of control bundle (write enables, mux selects, ALU op).
- DATA_W, 64: width of datapath bundle.
- NOP_CTRL, 0 (CTRL_W bits): control value driven whenever the stage holds a bubble.
- CNT_W, 16: width of bubble counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries (branch/interrupt redirect).
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; depends only on registered state.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream datapath bundle.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts (low = stall).
- out_ctrl  out  CTRL_W  control bundle; equals NOP_CTRL when out_valid=0.
- out_data  out  DATA_W  datapath bundle.
- bubble_cnt  out  CNT_W  count of cycles with out_valid=0 and out_ready=1, saturating.

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is rst.
- Storage: main entry (drives outputs) and skid entry. States: EMPTY, ONE (main valid), TWO (main+skid valid).
- Handshakes: fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
- in_ready = (state != TWO), decoded from the state register only; no combinational path from out_ready.
- out_valid = (state != EMPTY). out_ctrl = NOP_CTRL in EMPTY, else main ctrl. out_data = main data (holds its last value in EMPTY).
- Transitions (when flush=0, rst=0):
  - EMPTY: fire_in -> main<=in, ONE; else stay.
  - ONE: fire_in & fire_out -> main<=in, stay ONE. fire_in & !out_ready -> skid<=in, TWO. !fire_in & fire_out -> EMPTY. Neither -> hold.
  - TWO: in_ready=0. out_ready -> main<=skid, ONE; else hold both.
- Latency: a beat accepted at edge N is visible on out_* after edge N (1 cycle). Zero bubbles when out_ready is held high.
- Ordering: strictly FIFO; a skid beat is never overtaken.
- flush=1: next state EMPTY. Any input beat in the same cycle is dropped, even though in_ready=1 and in_valid=1. Outputs from the next cycle: out_valid=0, out_ctrl=NOP_CTRL. Data registers are not cleared.
- rst=1: state EMPTY, main/skid data=0, bubble_cnt=0. Beats in flight are discarded, and rst has priority over flush.
- Reset output values: out_valid=0, out_ctrl=NOP_CTRL, out_data=0, in_ready=1, bubble_cnt=0.
- bubble_cnt: increments by 1 on each cycle with out_valid=0 & out_ready=1. Saturates at 2^CNT_W-1 with no wrap. Unaffected by flush.
- Simultaneous flush and out_ready in TWO: flush wins, both entries dropped.

Test Plan:
- Reset then stream: in_valid=1 with in_data=0x01,0x02,0x03 on consecutive cycles, out_ready=1 -> out_data 0x01,0x02,0x03 one cycle later each, in_ready stays 1, bubble_cnt=1 (the first cycle only).
- Stall: send 0xA1 then 0xA2 with out_ready=0 -> state TWO, in_ready=0, out_data=0xA1. Raise out_ready -> 0xA1 then 0xA2 out in order, no loss or duplication.
- Flush in TWO with in_valid=1 (in_data=0xFF) and out_ready=1 -> next cycle out_valid=0, out_ctrl=NOP_CTRL (e.g. 0x0000 with in_ctrl=0x1234 held), 0xFF never emitted.
- Reset mid-stall in TWO -> next cycle out_valid=0, out_data=0, in_ready=1, bubble_cnt=0. A subsequent beat 0x55 passes normally.
- CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt reaches 15 and holds.
- Random valid/ready toggling for 10k cycles with a scoreboard -> output sequence equals the accepted input sequence, and in_ready never depends combinationally on out_ready.
